// File: rtl/riscv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_pkg
//
// Purpose: shared encodings for the multi-cycle RV32I sequencing controller.
//   Holds the FSM state codes, the opcodes the controller understands, the
//   internal ALUOp / external ALUControl encodings, and the datapath mux
//   select encodings.
//
// Ports: none (package).
// ----------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // FSM state codes, kept as plain constants so legacy tools and waveform
    // viewers that expect a bare 4-bit state register still work.
    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_JAL      = 4'd8;
    localparam state_t S_ALUWB    = 4'd9;
    localparam state_t S_BEQ      = 4'd10;

    // Opcodes (instr[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Internal ALUOp handed to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl seen by the shared ALU.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result mux.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A mux.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B mux.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format select.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, never on the state.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
//
// Purpose: combinational map from the controller's ALUOp plus instruction
//   fields to the 3-bit ALUControl driving the shared ALU.
//
// Ports:
//   i_alu_op       in  2  00 add, 01 sub, 10 decode from funct fields
//   i_funct3       in  3  instr[14:12]
//   i_funct7b5     in  1  instr[30]
//   i_op5          in  1  instr[5]; separates R-type (1) from I-type (0)
//   o_alu_control  out 3  ALU operation select
// ----------------------------------------------------------------------------
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    // Only an R-type instruction may select subtract through funct7; for
    // addi, instr[30] is just an immediate bit.
    logic w_is_sub;
    assign w_is_sub = i_op5 & i_funct7b5;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through the block leaves it unassigned and infers a latch.
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = w_is_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Purpose: sequencing FSM for the multi-cycle RV32I core. Steps one shared
//   ALU and one unified memory through fetch, decode, execute, memory and
//   writeback, and counts retired instructions.
//
// Parameters:
//   COUNT_WIDTH  width of the retired-instruction counter (wraps)
//
// Ports:
//   clk         in   1   core clock, rising edge
//   rst         in   1   synchronous active-high reset
//   op          in   7   instr[6:0]
//   funct3      in   3   instr[14:12]
//   funct7b5    in   1   instr[30]
//   Zero        in   1   ALU result == 0
//   mem_ready   in   1   memory completed current access this cycle
//   PCWrite     out  1   PC enable
//   AdrSrc      out  1   memory address: 0 PC, 1 ALUOut
//   MemWrite    out  1   memory write request
//   IRWrite     out  1   IR / OldPC enable
//   ResultSrc   out  2   00 ALUOut, 01 mem data, 10 ALU result
//   ALUSrcA     out  2   00 PC, 01 OldPC, 10 rs1
//   ALUSrcB     out  2   00 rs2, 01 ImmExt, 10 constant 4
//   ALUControl  out  3   ALU operation
//   ImmSrc      out  2   immediate format
//   RegWrite    out  1   register file write enable
//   illegal     out  1   one-cycle pulse on an unsupported opcode
//   retired     out  COUNT_WIDTH  instructions completed since reset
// ----------------------------------------------------------------------------
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             op,
    input  logic [2:0]             funct3,
    input  logic                   funct7b5,
    input  logic                   Zero,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   AdrSrc,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             ResultSrc,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUControl,
    output logic [1:0]             ImmSrc,
    output logic                   RegWrite,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] retired
);

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_retired;

    state_t     w_next_state;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_retire;

    // Next-state and per-state outputs. Everything is Moore except the
    // mem_ready-qualified enables in FETCH and the Zero-qualified PCWrite
    // in BEQ.
    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 goes straight to the PC while the instruction lands.
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = mem_ready;
                w_pc_write   = mem_ready;
                if (mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target OldPC+imm is computed here, ahead of BEQ.
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECUTER;
                    OP_ITYPE:          w_next_state = S_EXECUTEI;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_BRANCH:         w_next_state = S_BEQ;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (mem_ready) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_MEMDATA;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                // The write request stays up until memory accepts it.
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTER: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_JAL: begin
                // Jump target (computed in DECODE) goes to the PC while the
                // ALU forms the link value OldPC+4 for ALUWB.
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                w_pc_write   = Zero;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH.
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge
        // values regardless of statement order.
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_retired <= r_retired + COUNT_WIDTH'(1);
        end
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (ALUControl)
    );

    // Write strobes and illegal are suppressed while reset is high, so an
    // instruction abandoned by reset never issues a partial write.
    assign PCWrite   = w_pc_write  & ~rst;
    assign IRWrite   = w_ir_write  & ~rst;
    assign RegWrite  = w_reg_write & ~rst;
    assign MemWrite  = w_mem_write & ~rst;
    assign illegal   = w_illegal   & ~rst;
    assign AdrSrc    = w_adr_src;
    assign ResultSrc = w_result_src;
    assign ALUSrcA   = w_alu_src_a;
    assign ALUSrcB   = w_alu_src_b;
    assign ImmSrc    = imm_src_for(op);
    assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed instruction sequences for the multi-cycle controller. Each cycle
// of stimulus pushes the hand-derived control word expected for that cycle;
// a monitor pops one entry per falling edge and compares.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic        RegWrite;
    logic        illegal;
    logic [31:0] retired;

    multicycle_controller #(.COUNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pcw;
        logic        adr;
        logic        mw;
        logic        irw;
        logic [1:0]  rs;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [2:0]  alu;
        logic [1:0]  imm;
        logic        rw;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    // Pending instruction fields, applied just after the next rising edge.
    logic [6:0]  p_op  = 7'b0110011;
    logic [2:0]  p_f3  = 3'b000;
    logic        p_f7  = 1'b0;
    logic [1:0]  cur_imm = 2'b00;
    logic [31:0] exp_ret = 32'd0;

    // ---------------- expected control words, one per state -------------
    function automatic exp_t base(input string n);
        exp_t e;
        e.name = n;  e.pcw = 1'b0; e.adr = 1'b0; e.mw = 1'b0; e.irw = 1'b0;
        e.rs = 2'b00; e.sa = 2'b00; e.sb = 2'b00; e.alu = 3'b000;
        e.imm = cur_imm; e.rw = 1'b0; e.ill = 1'b0; e.ret = exp_ret;
        return e;
    endfunction

    function automatic exp_t e_fetch(input string n, input logic en);
        exp_t e = base(n);
        e.pcw = en; e.irw = en; e.rs = 2'b10; e.sb = 2'b10;
        return e;
    endfunction

    function automatic exp_t e_decode(input string n, input logic ill);
        exp_t e = base(n);
        e.sa = 2'b01; e.sb = 2'b01; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t e_memadr(input string n);
        exp_t e = base(n);
        e.sa = 2'b10; e.sb = 2'b01;
        return e;
    endfunction

    function automatic exp_t e_memread(input string n);
        exp_t e = base(n);
        e.adr = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memwb(input string n);
        exp_t e = base(n);
        e.rs = 2'b01; e.rw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memwrite(input string n, input logic mw);
        exp_t e = base(n);
        e.adr = 1'b1; e.mw = mw;
        return e;
    endfunction

    function automatic exp_t e_exec(input string n, input logic [1:0] sb,
                                    input logic [2:0] alu);
        exp_t e = base(n);
        e.sa = 2'b10; e.sb = sb; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t e_jal(input string n);
        exp_t e = base(n);
        e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_aluwb(input string n);
        exp_t e = base(n);
        e.rw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_beq(input string n, input logic taken);
        exp_t e = base(n);
        e.sa = 2'b10; e.alu = 3'b001; e.pcw = taken;
        return e;
    endfunction

    // ---------------- stimulus ----------------
    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [1:0] imm);
        p_op = o; p_f3 = f3; p_f7 = f7; cur_imm = imm;
    endtask

    task automatic cyc(input exp_t e, input logic r, input logic mr,
                       input logic z);
        @(posedge clk);
        #1;
        op = p_op; funct3 = p_f3; funct7b5 = p_f7;
        rst = r; mem_ready = mr; Zero = z;
        exp_q.push_back(e);
    endtask

    task automatic do_alu(input string n, input logic [6:0] o,
                          input logic [2:0] f3, input logic f7,
                          input logic [2:0] alu);
        set_instr(o, f3, f7, 2'b00);
        cyc(e_fetch({n, ".fetch"}, 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode({n, ".decode"}, 1'b0), 1'b0, 1'b1, 1'b0);
        if (o[5]) cyc(e_exec({n, ".execr"}, 2'b00, alu), 1'b0, 1'b1, 1'b0);
        else      cyc(e_exec({n, ".execi"}, 2'b01, alu), 1'b0, 1'b1, 1'b0);
        cyc(e_aluwb({n, ".aluwb"}), 1'b0, 1'b1, 1'b0);
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic do_beq(input string n, input logic z);
        set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
        cyc(e_fetch({n, ".fetch"}, 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode({n, ".decode"}, 1'b0), 1'b0, 1'b1, 1'b0);
        cyc(e_beq({n, ".beq"}, z), 1'b0, 1'b1, z);
        exp_ret = exp_ret + 32'd1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t        m_e;
    logic [16:0] m_act;
    logic [16:0] m_exp;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e   = exp_q.pop_front();
            m_act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal};
            m_exp = {m_e.pcw, m_e.adr, m_e.mw, m_e.irw, m_e.rs, m_e.sa,
                     m_e.sb, m_e.alu, m_e.imm, m_e.rw, m_e.ill};
            n_vec++;
            if (m_act !== m_exp || retired !== m_e.ret) begin
                n_miss++;
                $display("FAIL %s: got ctl=%05h retired=%0d, expected ctl=%05h retired=%0d",
                         m_e.name, m_act, retired, m_exp, m_e.ret);
            end
        end
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;

        // Reset held over two edges; write enables stay low even with
        // mem_ready high.
        cyc(e_fetch("reset.c1", 1'b0), 1'b1, 1'b1, 1'b0);
        cyc(e_fetch("reset.c2", 1'b0), 1'b1, 1'b1, 1'b0);

        // ALU instructions: R-type and I-type funct decode.
        do_alu("add",  7'b0110011, 3'b000, 1'b0, 3'b000);
        do_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
        do_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000);
        do_alu("andi", 7'b0010011, 3'b111, 1'b0, 3'b010);
        do_alu("or",   7'b0110011, 3'b110, 1'b0, 3'b011);
        do_alu("slt",  7'b0110011, 3'b010, 1'b0, 3'b101);
        do_alu("sll",  7'b0110011, 3'b001, 1'b0, 3'b000);

        // lw with memory stalled for two cycles in MEMREAD: 7 cycles.
        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        cyc(e_fetch("lw.fetch", 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode("lw.decode", 1'b0), 1'b0, 1'b1, 1'b0);
        cyc(e_memadr("lw.memadr"), 1'b0, 1'b1, 1'b0);
        cyc(e_memread("lw.memread.w1"), 1'b0, 1'b0, 1'b0);
        cyc(e_memread("lw.memread.w2"), 1'b0, 1'b0, 1'b0);
        cyc(e_memread("lw.memread.rdy"), 1'b0, 1'b1, 1'b0);
        cyc(e_memwb("lw.memwb"), 1'b0, 1'b1, 1'b0);
        exp_ret = exp_ret + 32'd1;

        // sw with a one-cycle fetch stall.
        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        cyc(e_fetch("sw.fetch.wait", 1'b0), 1'b0, 1'b0, 1'b0);
        cyc(e_fetch("sw.fetch.rdy", 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode("sw.decode", 1'b0), 1'b0, 1'b1, 1'b0);
        cyc(e_memadr("sw.memadr"), 1'b0, 1'b1, 1'b0);
        cyc(e_memwrite("sw.memwrite", 1'b1), 1'b0, 1'b1, 1'b0);
        exp_ret = exp_ret + 32'd1;

        // Branches taken and not taken.
        do_beq("beq_taken", 1'b1);
        do_beq("beq_not", 1'b0);

        // jal.
        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
        cyc(e_fetch("jal.fetch", 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode("jal.decode", 1'b0), 1'b0, 1'b1, 1'b0);
        cyc(e_jal("jal.jal"), 1'b0, 1'b1, 1'b0);
        cyc(e_aluwb("jal.aluwb"), 1'b0, 1'b1, 1'b0);
        exp_ret = exp_ret + 32'd1;

        // Illegal opcode: pulse in DECODE, back to FETCH, no retire.
        set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
        cyc(e_fetch("ill.fetch", 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode("ill.decode", 1'b1), 1'b0, 1'b1, 1'b0);

        // sw abandoned by reset while stalled in MEMWRITE.
        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        cyc(e_fetch("swrst.fetch", 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode("swrst.decode", 1'b0), 1'b0, 1'b1, 1'b0);
        cyc(e_memadr("swrst.memadr"), 1'b0, 1'b1, 1'b0);
        cyc(e_memwrite("swrst.memwrite.wait", 1'b1), 1'b0, 1'b0, 1'b0);
        cyc(e_memwrite("swrst.memwrite.rst", 1'b0), 1'b1, 1'b0, 1'b0);
        exp_ret = 32'd0;
        cyc(e_fetch("swrst.fetch.inrst", 1'b0), 1'b1, 1'b1, 1'b0);
        cyc(e_fetch("swrst.fetch.after", 1'b1), 1'b0, 1'b1, 1'b0);
        cyc(e_decode("swrst.decode.after", 1'b0), 1'b0, 1'b1, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
